// File: rtl/inst_loader.sv
// inst_loader: receives a little-endian byte stream and writes it word by word
// into instruction memory while holding the core out of fetch.
`default_nettype none

module inst_loader #(
   parameter int unsigned DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  len_words,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        we,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  word_cnt_q, word_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] buf_q, buf_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         buf_q      <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         buf_q      <= buf_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      buf_d      = buf_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               if (len_words == 8'd0) begin
                  state_d = S_DONE;
               end else if (32'(len_words) > DEPTH_WORDS) begin
                  state_d = S_ERR;
               end else begin
                  len_d      = len_words;
                  word_cnt_d = '0;
                  byte_cnt_d = '0;
                  state_d    = S_RECV;
               end
            end
         end
         S_RECV: begin
            if (byte_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0: buf_d[7:0]   = byte_data;
                  2'd1: buf_d[15:8]  = byte_data;
                  2'd2: buf_d[23:16] = byte_data;
                  default: begin
                     // Output registers are loaded only here so they hold between writes.
                     wdata_d = {byte_data, buf_q};
                     waddr_d = {22'd0, word_cnt_q, 2'b00};
                     state_d = S_WRITE;
                  end
               endcase
            end
         end
         S_WRITE: begin
            word_cnt_d = word_cnt_q + 8'd1;
            state_d    = (word_cnt_d == len_q) ? S_DONE : S_RECV;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign byte_ready = (state_q == S_RECV);
   assign we         = (state_q == S_WRITE);
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
   assign cpu_hold   = (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
`default_nettype none

module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  len_words = '0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready, we, cpu_hold, busy, done, err;
   logic [31:0] waddr, wdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int nwe   = 0;
   logic [31:0] cap_a [8];
   logic [31:0] cap_d [8];

   logic [7:0] prog [8] = '{8'h93, 8'h00, 8'h30, 8'h0F, 8'h13, 8'h01, 8'h90, 8'h00};

   inst_loader #(.DEPTH_WORDS(64)) dut (
      .clk(clk), .rst(rst), .start(start), .len_words(len_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (we === 1'b1) begin
         if (nwe < 8) begin
            cap_a[nwe] = waddr;
            cap_d[nwe] = wdata;
         end
         nwe++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one byte and hold it until the loader takes it.
   task automatic send(input logic [7:0] b, input bit gap);
      int guard = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      chk("byte_ready_wait", 32'(byte_ready), 32'd1);
      tick();
      if (gap) begin
         byte_valid = 1'b0;
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      chk({tag, "_we"},         32'(we),         32'd0);
      chk({tag, "_waddr"},      waddr,           32'd0);
      chk({tag, "_wdata"},      wdata,           32'd0);
      chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_done"},       32'(done),       32'd0);
      chk({tag, "_err"},        32'(err),        32'd0);
   endtask

   task automatic pulse_start(input logic [7:0] len);
      start = 1'b1; len_words = len;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int c0;

      // Reset state
      do_reset();
      check_idle_outputs("reset");

      // Two-word back-to-back load
      nwe = 0;
      pulse_start(8'd2);
      c0 = cyc;
      chk("recv_busy", 32'(busy), 32'd1);
      chk("recv_ready", 32'(byte_ready), 32'd1);
      for (int i = 0; i < 8; i++) send(prog[i], 1'b0);
      byte_valid = 1'b0;
      chk("b2b_cycles", 32'(cyc - c0), 32'd9);
      chk("b2b_we2", 32'(we), 32'd1);
      chk("b2b_hold_in_write", 32'(cpu_hold), 32'd1);
      chk("b2b_done_early", 32'(done), 32'd0);
      tick();
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_cpu_hold", 32'(cpu_hold), 32'd0);
      chk("b2b_busy", 32'(busy), 32'd0);
      chk("b2b_nwe", 32'(nwe), 32'd2);
      chk("b2b_a0", cap_a[0], 32'h0);
      chk("b2b_d0", cap_d[0], 32'h0F300093);
      chk("b2b_a1", cap_a[1], 32'h4);
      chk("b2b_d1", cap_d[1], 32'h00900113);
      tick();
      chk("hold_waddr", waddr, 32'h4);
      chk("hold_wdata", wdata, 32'h00900113);

      // Same stream with gaps, restarted from DONE
      nwe = 0;
      pulse_start(8'd2);
      chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("restart_done", 32'(done), 32'd0);
      for (int i = 0; i < 8; i++) send(prog[i], 1'b1);
      for (int i = 0; i < 3; i++) tick();
      chk("gap_done", 32'(done), 32'd1);
      chk("gap_nwe", 32'(nwe), 32'd2);
      chk("gap_a0", cap_a[0], 32'h0);
      chk("gap_d0", cap_d[0], 32'h0F300093);
      chk("gap_a1", cap_a[1], 32'h4);
      chk("gap_d1", cap_d[1], 32'h00900113);

      // Zero-length session
      do_reset();
      nwe = 0;
      pulse_start(8'd0);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      tick();
      chk("zero_nwe", 32'(nwe), 32'd0);

      // Oversized length rejected; bytes ignored
      pulse_start(8'd65);
      chk("err_flag", 32'(err), 32'd1);
      chk("err_hold", 32'(cpu_hold), 32'd1);
      chk("err_done", 32'(done), 32'd0);
      byte_valid = 1'b1; byte_data = 8'h5A;
      tick(); tick();
      chk("err_ready", 32'(byte_ready), 32'd0);
      chk("err_stays", 32'(err), 32'd1);
      byte_valid = 1'b0;

      // Recovery from ERR with len=1
      nwe = 0;
      pulse_start(8'd1);
      chk("recover_busy", 32'(busy), 32'd1);
      chk("recover_err", 32'(err), 32'd0);
      send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
      byte_valid = 1'b0;
      tick();
      chk("recover_done", 32'(done), 32'd1);
      chk("recover_nwe", 32'(nwe), 32'd1);
      chk("recover_d0", cap_d[0], 32'hDDCCBBAA);

      // Boundary length accepted, then reset mid-word
      pulse_start(8'd64);
      chk("len64_busy", 32'(busy), 32'd1);
      chk("len64_err", 32'(err), 32'd0);
      nwe = 0;
      send(8'hE1, 1'b0); send(8'hE2, 1'b0);
      byte_valid = 1'b1; byte_data = 8'hE3;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      byte_valid = 1'b0;
      check_idle_outputs("midreset");
      tick();
      chk("midreset_nwe", 32'(nwe), 32'd0);
      pulse_start(8'd1);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
      byte_valid = 1'b0;
      tick();
      chk("fresh_nwe", 32'(nwe), 32'd1);
      chk("fresh_a0", cap_a[0], 32'h0);
      chk("fresh_d0", cap_d[0], 32'h44332211);

      // Start pulsed during RECV is ignored
      nwe = 0;
      pulse_start(8'd3);
      for (int i = 0; i < 6; i++) send(8'(i), 1'b0);
      byte_valid = 1'b0;
      start = 1'b1; len_words = 8'd1;
      tick();
      start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      for (int i = 6; i < 12; i++) send(8'(i), 1'b0);
      byte_valid = 1'b0;
      tick();
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_nwe", 32'(nwe), 32'd3);
      chk("ign_a0", cap_a[0], 32'h0);
      chk("ign_d0", cap_d[0], 32'h03020100);
      chk("ign_a1", cap_a[1], 32'h4);
      chk("ign_d1", cap_d[1], 32'h07060504);
      chk("ign_a2", cap_a[2], 32'h8);
      chk("ign_d2", cap_d[2], 32'h0B0A0908);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, maximum number of 32-bit words loadable into instruction memory.
REQ-002 Port list, one per line: name  direction  width  meaning; clock and reset come first.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  one-cycle pulse that begins a load session.
- len_words  in  8  number of words to load; sampled on accepted start.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  program byte, little-endian within each word.
- byte_ready  out  1  loader can accept a byte this cycle.
- we  out  1  instruction-memory write strobe.
- waddr  out  32  byte address of the write; always word-aligned.
- wdata  out  32  instruction word being written.
- cpu_hold  out  1  holds the core out of fetch while high.
- busy  out  1  session in progress.
- done  out  1  last session completed successfully.
- err  out  1  last start was rejected.

Function
REQ-003 The FSM SHALL have states IDLE, RECV, WRITE, DONE and ERR.
REQ-004 A byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1.
REQ-005 byte_ready SHALL be 1 only in RECV.
REQ-006 In IDLE, DONE or ERR, start=1 SHALL be handled as follows:
- len_words=0: go to DONE next cycle.
- len_words>DEPTH_WORDS: go to ERR.
- otherwise: latch len_words, clear the byte and word counters, go to RECV.
REQ-007 start SHALL be ignored in RECV and WRITE.
REQ-008 In RECV, the k-th accepted byte of a word (k=0..3) SHALL be stored at word bits [8k+7:8k].
- The 4th accepted byte SHALL move the FSM to WRITE on the next cycle.
REQ-009 WRITE SHALL last exactly one cycle with we=1, waddr=word_cnt*4 and wdata=assembled word.
- After WRITE, word_cnt SHALL increment.
- The FSM SHALL go to DONE if the incremented count equals the latched length; otherwise it SHALL return to RECV.
REQ-010 we SHALL be 0 in every state other than WRITE; waddr and wdata SHALL hold their last values while we=0.
REQ-011 Minimum cost SHALL be 5 cycles per word: 4 RECV cycles plus 1 WRITE cycle.
- Gaps in byte_valid SHALL only stretch RECV.
REQ-012 busy SHALL be 1 exactly in RECV and WRITE.
REQ-013 cpu_hold SHALL be 0 only in DONE and 1 in all other states.
- A restart from DONE SHALL reassert cpu_hold on the next cycle.
REQ-014 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-015 Bytes presented outside RECV SHALL be neither consumed nor stored.
REQ-016 Counters SHALL never wrap, because len_words is bounded by DEPTH_WORDS before RECV is entered.

Reset
REQ-017 rst=1 at a clock edge SHALL force the following, overriding all other inputs:
- state IDLE;
- byte_ready=0, we=0, waddr=0, wdata=0;
- cpu_hold=1;
- busy=0, done=0, err=0;
- counters and the word buffer cleared.
REQ-018 Reset in the middle of a word SHALL discard the partial word and produce no write strobe.

Verification
REQ-019 Reset, start len=2, bytes 93,00,30,0F,13,01,90,00 back-to-back -> we at waddr 0x0 with wdata 0x0F300093, then at waddr 0x4 with wdata 0x00900113; done=1 and cpu_hold=0 one cycle after the 2nd write.
REQ-020 Same stream as REQ-019 with byte_valid toggling every other cycle -> identical write contents, exactly 2 we pulses.
REQ-021 start with len_words=0 -> done=1 next cycle, we never asserted.
REQ-022 start with len_words=65 -> err=1, cpu_hold=1, byte_ready stays 0; a later start with len=1 recovers to RECV.
REQ-023 rst after 2 bytes of word 0 -> all outputs at reset values, no we; a fresh session writes waddr 0 correctly.
REQ-024 start pulsed during RECV -> ignored; word count and addresses unchanged.
